// File: rtl/video_timing_sequencer.sv
// Raster timing generator for the DVI test-pattern path.
// Produces hsync/vsync/active_pixel plus aligned h/v counters and sequences
// the pattern index at frame boundaries. Start and stop are frame-clean.
module video_timing_sequencer #(
  parameter int unsigned H_ACTIVE           = 1280,
  parameter int unsigned H_FP               = 110,
  parameter int unsigned H_SYNC             = 40,
  parameter int unsigned H_BP               = 220,
  parameter int unsigned V_ACTIVE           = 720,
  parameter int unsigned V_FP               = 5,
  parameter int unsigned V_SYNC             = 5,
  parameter int unsigned V_BP               = 20,
  parameter int unsigned FRAMES_PER_PATTERN = 60,
  parameter int unsigned NUM_PATTERNS       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        active_pixel,
  output logic [11:0] h_count,
  output logic [11:0] v_count,
  output logic        frame_start,
  output logic [1:0]  pattern_sel,
  output logic        running
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Frame counter must be able to hold FRAMES_PER_PATTERN itself: a frame
  // that completes while draining leaves a pending advance for the next start.
  localparam int unsigned FC_W = (FRAMES_PER_PATTERN < 2) ? 1 : $clog2(FRAMES_PER_PATTERN + 1);

  localparam logic [11:0]     H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0]     V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [12:0]     H_ACT_W  = 13'(H_ACTIVE);
  localparam logic [12:0]     V_ACT_W  = 13'(V_ACTIVE);
  localparam logic [12:0]     HS_BEGIN = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0]     HS_END   = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0]     VS_BEGIN = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0]     VS_END   = 13'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [FC_W-1:0] FC_LAST  = FC_W'(FRAMES_PER_PATTERN - 1);
  localparam logic [FC_W-1:0] FC_FULL  = FC_W'(FRAMES_PER_PATTERN);
  localparam logic [1:0]      PAT_LAST = 2'(NUM_PATTERNS - 1);

  if (H_TOTAL > 4096 || V_TOTAL > 4096 || H_TOTAL == 0 || V_TOTAL == 0 ||
      FRAMES_PER_PATTERN == 0 || NUM_PATTERNS == 0 || NUM_PATTERNS > 4) begin : g_bad_params
    $error("video_timing_sequencer: unsupported parameter set");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state;
  logic [FC_W-1:0] frame_cnt;

  logic        h_last;
  logic        v_last;
  logic        frame_end;
  logic        run_nxt;
  logic        fs_nxt;
  logic [11:0] h_nxt;
  logic [11:0] v_nxt;
  logic        hs_nxt;
  logic        vs_nxt;
  logic        act_nxt;
  logic [1:0]  pat_next;

  // Next raster position and its decode; every output register loads from
  // this one position so all outputs stay aligned with h_count/v_count.
  always_comb begin
    h_last    = (h_count == H_LAST);
    v_last    = (v_count == V_LAST);
    frame_end = (state != IDLE) && h_last && v_last;

    if (state == IDLE) begin
      run_nxt = enable;
      fs_nxt  = enable;
    end else begin
      run_nxt = enable || !frame_end;
      fs_nxt  = enable && frame_end;
    end

    if (state == IDLE || h_last) begin
      h_nxt = '0;
    end else begin
      h_nxt = h_count + 12'd1;
    end

    if (state == IDLE || (h_last && v_last)) begin
      v_nxt = '0;
    end else if (h_last) begin
      v_nxt = v_count + 12'd1;
    end else begin
      v_nxt = v_count;
    end

    act_nxt = run_nxt && ({1'b0, h_nxt} < H_ACT_W) && ({1'b0, v_nxt} < V_ACT_W);
    hs_nxt  = run_nxt && ({1'b0, h_nxt} >= HS_BEGIN) && ({1'b0, h_nxt} < HS_END);
    vs_nxt  = run_nxt && ({1'b0, v_nxt} >= VS_BEGIN) && ({1'b0, v_nxt} < VS_END);

    pat_next = (pattern_sel == PAT_LAST) ? '0 : pattern_sel + 2'd1;
  end

  // Control FSM, registered raster outputs and pattern sequencing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      running      <= 1'b0;
      frame_start  <= 1'b0;
      h_count      <= '0;
      v_count      <= '0;
      hsync_out    <= 1'b0;
      vsync_out    <= 1'b0;
      active_pixel <= 1'b0;
      pattern_sel  <= '0;
      frame_cnt    <= '0;
    end else begin
      if (!run_nxt) begin
        state <= IDLE;
      end else if (enable) begin
        state <= RUN;
      end else begin
        state <= DRAIN;
      end

      running      <= run_nxt;
      frame_start  <= fs_nxt;
      h_count      <= h_nxt;
      v_count      <= v_nxt;
      hsync_out    <= hs_nxt;
      vsync_out    <= vs_nxt;
      active_pixel <= act_nxt;

      // frame_cnt counts completed frames of the current pattern. A wrap
      // advances on the FRAMES_PER_PATTERN-th completion; a start from IDLE
      // advances only if the last drained frame filled the count.
      if (fs_nxt) begin
        if (frame_cnt == ((state == IDLE) ? FC_FULL : FC_LAST)) begin
          frame_cnt   <= '0;
          pattern_sel <= pat_next;
        end else if (state != IDLE) begin
          frame_cnt <= frame_cnt + FC_W'(1);
        end
      end else if (frame_end) begin
        frame_cnt <= frame_cnt + FC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_video_timing_sequencer.sv
// Bench for video_timing_sequencer with a 16x8 raster, 2 frames per pattern.
module tb_video_timing_sequencer;

  localparam int HT  = 16;
  localparam int VT  = 8;
  localparam int FPP = 2;
  localparam int NP  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        hsync_out;
  logic        vsync_out;
  logic        active_pixel;
  logic [11:0] h_count;
  logic [11:0] v_count;
  logic        frame_start;
  logic [1:0]  pattern_sel;
  logic        running;

  video_timing_sequencer #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .FRAMES_PER_PATTERN(FPP), .NUM_PATTERNS(NP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .hsync_out(hsync_out),
    .vsync_out(vsync_out),
    .active_pixel(active_pixel),
    .h_count(h_count),
    .v_count(v_count),
    .frame_start(frame_start),
    .pattern_sel(pattern_sel),
    .running(running)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        pad;
    logic        hs;
    logic        vs;
    logic        act;
    logic        fs;
    logic        run;
    logic [1:0]  pat;
    logic [11:0] h;
    logic [11:0] v;
  } obs_t;

  typedef struct {
    int   off;
    int   h;
    int   v;
    logic hs;
    logic vs;
    logic act;
  } vec_t;

  obs_t q[$];
  int   pat_hist[$];
  int   gap_hist[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_fs = -1;
  int   fs_cnt = 0;

  // reference model state
  bit m_on;
  int m_h, m_v, m_fc, m_pat;
  bit m_fs;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic obs_t dut_obs();
    obs_t o;
    o.pad = 1'b0;
    o.hs  = hsync_out;
    o.vs  = vsync_out;
    o.act = active_pixel;
    o.fs  = frame_start;
    o.run = running;
    o.pat = pattern_sel;
    o.h   = h_count;
    o.v   = v_count;
    return o;
  endfunction

  task automatic model_reset();
    m_on = 0; m_h = 0; m_v = 0; m_fc = 0; m_pat = 0; m_fs = 0;
    q.delete();
  endtask

  // Advance the model by one clock given the enable it will sample; push the
  // outputs expected after that edge.
  task automatic model_step(input bit e);
    obs_t x;
    m_fs = 0;
    if (!m_on) begin
      if (e) begin
        m_on = 1; m_h = 0; m_v = 0; m_fs = 1;
        if (m_fc == FPP) begin
          m_fc = 0; m_pat = (m_pat + 1) % NP;
        end
      end
    end else if (m_h == HT - 1 && m_v == VT - 1) begin
      m_h = 0; m_v = 0;
      if (e) begin
        m_fs = 1;
        if (m_fc == FPP - 1) begin
          m_fc = 0; m_pat = (m_pat + 1) % NP;
        end else begin
          m_fc++;
        end
      end else begin
        m_on = 0;
        m_fc++;
      end
    end else if (m_h == HT - 1) begin
      m_h = 0; m_v++;
    end else begin
      m_h++;
    end
    x.pad = 1'b0;
    x.run = m_on;
    x.fs  = m_fs;
    x.pat = 2'(m_pat);
    x.h   = 12'(m_h);
    x.v   = 12'(m_v);
    x.act = m_on && m_h < 8 && m_v < 4;
    x.hs  = m_on && m_h >= 10 && m_h <= 12;
    x.vs  = m_on && m_v >= 5 && m_v <= 6;
    q.push_back(x);
  endtask

  // Called at a negedge: drive enable, predict, then compare after the edge.
  task automatic cycle(input bit e);
    obs_t got;
    obs_t exp_o;
    enable = e;
    model_step(e);
    @(negedge clk);
    cyc++;
    got   = dut_obs();
    exp_o = q.pop_front();
    check("raster", 32'(got), 32'(exp_o));
    if (got.fs === 1'b1) begin
      fs_cnt++;
      pat_hist.push_back(int'(got.pat));
      if (last_fs >= 0) gap_hist.push_back(cyc - last_fs);
      last_fs = cyc;
    end
  endtask

  task automatic run_to(input int h, input int v, input bit e);
    int n;
    n = 0;
    do begin
      cycle(e);
      n++;
    end while (!(m_h == h && m_v == v) && n < 400);
    if (!(m_h == h && m_v == v)) begin
      total++;
      bad++;
      $display("FAIL run_to_timeout: got h=%0d v=%0d want h=%0d v=%0d", m_h, m_v, h, v);
    end
  endtask

  initial begin
    vec_t tab[12];
    int   pat_exp[9];
    int   cur;
    int   fs_saved;
    obs_t o;

    pat_exp = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    //         off  h   v   hs    vs    act
    tab[0]  = '{0,   0,  0, 1'b0, 1'b0, 1'b1};
    tab[1]  = '{25,  9,  1, 1'b0, 1'b0, 1'b0};
    tab[2]  = '{26,  10, 1, 1'b1, 1'b0, 1'b0};
    tab[3]  = '{55,  7,  3, 1'b0, 1'b0, 1'b1};
    tab[4]  = '{56,  8,  3, 1'b0, 1'b0, 1'b0};
    tab[5]  = '{76,  12, 4, 1'b1, 1'b0, 1'b0};
    tab[6]  = '{77,  13, 4, 1'b0, 1'b0, 1'b0};
    tab[7]  = '{80,  0,  5, 1'b0, 1'b1, 1'b0};
    tab[8]  = '{91,  11, 5, 1'b1, 1'b1, 1'b0};
    tab[9]  = '{111, 15, 6, 1'b0, 1'b1, 1'b0};
    tab[10] = '{112, 0,  7, 1'b0, 1'b0, 1'b0};
    tab[11] = '{127, 15, 7, 1'b0, 1'b0, 1'b0};

    model_reset();
    repeat (3) @(negedge clk);
    check("reset_state", 32'(dut_obs()), 32'd0);
    reset = 1'b0;

    // idle with enable low, then start
    repeat (200) cycle(1'b0);
    pat_hist.delete();
    gap_hist.delete();
    cycle(1'b1);
    o = dut_obs();
    check("first_start", 32'({o.fs, o.run, o.h, o.v}), 32'({1'b1, 1'b1, 12'd0, 12'd0}));

    // nine frames of pattern sequencing
    repeat (8 * 128) cycle(1'b1);
    check("pat_frames", 32'(pat_hist.size()), 32'd9);
    for (int i = 0; i < 9 && i < pat_hist.size(); i++)
      check($sformatf("pat_frame%0d", i), 32'(pat_hist[i]), 32'(pat_exp[i]));
    foreach (gap_hist[i])
      check("frame_period", 32'(gap_hist[i]), 32'd128);

    // decode points within frame 9 (DUT currently at offset 0)
    cur = 0;
    for (int i = 0; i < 12; i++) begin
      repeat (tab[i].off - cur) cycle(1'b1);
      cur = tab[i].off;
      o = dut_obs();
      check($sformatf("decode_h%0d_v%0d", tab[i].h, tab[i].v),
            32'({o.h, o.v, o.hs, o.vs, o.act}),
            32'({12'(tab[i].h), 12'(tab[i].v), tab[i].hs, tab[i].vs, tab[i].act}));
    end

    // drain: drop enable at h=3,v=2 of the next frame
    cycle(1'b1);
    run_to(3, 2, 1'b1);
    run_to(15, 7, 1'b0);
    o = dut_obs();
    check("drain_last", 32'({o.run, o.h, o.v}), 32'({1'b1, 12'd15, 12'd7}));
    fs_saved = fs_cnt;
    cycle(1'b0);
    o = dut_obs();
    check("drain_idle", 32'({o.run, o.hs, o.vs, o.act, o.fs}), 32'd0);
    repeat (40) cycle(1'b0);
    check("no_restart", 32'(fs_cnt), 32'(fs_saved));

    // enable dip inside a frame must not disturb the raster
    cycle(1'b1);
    run_to(4, 3, 1'b1);
    repeat (6) cycle(1'b0);
    run_to(0, 0, 1'b1);
    check("dip_gap", 32'(gap_hist[gap_hist.size() - 1]), 32'd128);

    // asynchronous reset mid-frame
    run_to(5, 1, 1'b1);
    reset = 1'b1;
    #1;
    check("async_reset", 32'(dut_obs()), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    cycle(1'b1);
    o = dut_obs();
    check("restart", 32'({o.fs, o.run, o.pat, o.h, o.v}),
          32'({1'b1, 1'b1, 2'd0, 12'd0, 12'd0}));
    repeat (130) cycle(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/video_timing_sequencer.md
Name: video_timing_sequencer

Overview:
Generates the raster timing (hsync, vsync, active_pixel) that drives the DVI test-pattern datapath on the KC705 LPC FMC design. It also sequences pattern selection, advancing a pattern index every FRAMES_PER_PATTERN frames at frame boundaries only. It sits between the pixel-clock domain's control logic and the pattern generator / DVI transmitter. Start/stop is frame-clean: the block never truncates a frame.

Parameters:
H_ACTIVE, 1280, active pixels per line
H_FP, 110, horizontal front porch (clocks)
H_SYNC, 40, hsync width (clocks)
H_BP, 220, horizontal back porch (clocks)
V_ACTIVE, 720, active lines per frame
V_FP, 5, vertical front porch (lines)
V_SYNC, 5, vsync width (lines)
V_BP, 20, vertical back porch (lines)
FRAMES_PER_PATTERN, 60, frames shown per pattern before advancing
NUM_PATTERNS, 4, number of patterns; pattern_sel wraps at NUM_PATTERNS-1

Ports:
clk  input  1  pixel clock
reset  input  1  asynchronous, active-high reset
enable  input  1  level; 1 = run raster, 0 = stop at end of current frame
hsync_out  output  1  horizontal sync, active-high
vsync_out  output  1  vertical sync, active-high
active_pixel  output  1  1 during active video region
h_count  output  12  horizontal position aligned with the other outputs
v_count  output  12  vertical position aligned with the other outputs
frame_start  output  1  one-cycle pulse at h=0, v=0 of each frame
pattern_sel  output  2  current pattern index, stable for a whole frame
running  output  1  1 in RUN or DRAIN

Behaviour:
- Interface: one clock, clk. reset is asynchronous and active-high. All outputs are registered.
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise. Both must be ≤ 4096.
- Reset values: all outputs 0. Internal frame counter is 0. State is IDLE.
- States:
  - IDLE: counters held at 0; hsync_out, vsync_out, active_pixel and frame_start all 0.
  - RUN: raster is generated normally.
  - DRAIN: raster continues, but the block returns to IDLE when the frame ends.
- Transitions:
  - IDLE→RUN when enable=1. The first raster cycle (h=0, v=0, frame_start=1) appears one clk after enable is sampled high.
  - RUN→DRAIN when enable=0.
  - DRAIN→RUN when enable=1. This is seamless: no counter disturbance and no extra frame_start.
  - DRAIN→IDLE on the cycle after h=H_TOTAL-1, v=V_TOTAL-1 has been output.
  - RUN at the end of a frame wraps to h=0, v=0 with no gap.
- Counters: h increments each clk and wraps at H_TOTAL-1 to 0. v increments only when h wraps, and wraps at V_TOTAL-1 to 0.
- Decode, from the same registered counter state, with no skew between outputs:
  - active_pixel = (h < H_ACTIVE) && (v < V_ACTIVE)
  - hsync_out = 1 for H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC, on every line including blanking lines
  - vsync_out = 1 for V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC, over whole lines (asserts and deasserts at h=0)
- Pattern sequencing:
  - At each frame_start, the frame counter increments.
  - When the frame counter reaches FRAMES_PER_PATTERN-1 and a new frame starts, the frame counter clears to 0. On that same frame_start cycle pattern_sel advances (NUM_PATTERNS-1 → 0).
  - pattern_sel and the frame counter are retained through IDLE; only reset clears them.
  - The first frame after IDLE→RUN does not advance pattern_sel unless the count rule is met.
- Reset mid-frame: all outputs go to 0 immediately (asynchronous) and the state is IDLE. After reset releases, the block restarts from IDLE per the enable rules.
- enable toggling within a frame: only its value at the last cycle of the frame decides whether the next frame starts.

Test Plan:
- Small params H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=3, V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1, enable=1 from reset release -> frame_start every 128 clks; active_pixel high for h 0..7 on v 0..3 (32 clks per frame); hsync_out high for h 10..12 on all 8 lines; vsync_out high for v 5..6 (32 clks).
- Same params, FRAMES_PER_PATTERN=2, NUM_PATTERNS=4, run 9 frames -> pattern_sel sequence per frame 0,0,1,1,2,2,3,3,0; changes only on frame_start cycles.
- Deassert enable at h=3, v=2 -> raster continues to h=15, v=7; next cycle running=0 and all sync/active outputs 0; no further frame_start.
- Deassert then reassert enable within the same frame -> no gap: next frame_start exactly 128 clks after the previous one; running stays 1.
- Assert reset at h=5, v=1 mid-frame -> all outputs 0 within the same cycle (asynchronous); after release with enable=1, frame_start occurs one clk after the first sampled enable; pattern_sel=0.
- Hold enable=0 from reset for 200 clks -> all outputs stay 0; then enable=1 -> h_count=0, v_count=0, frame_start=1 on the following cycle.
